// File: rtl/hazard_controller_pkg.sv
// rtl/hazard_controller_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_controller_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALTED   = 2'd3
  } hazard_state_t;

  typedef struct packed {
    logic en;
    logic bubble;
  } stage_ctrl_t;

  localparam int NUM_STAGES = 5;
  localparam int STG_FETCH  = 0;
  localparam int STG_DECODE = 1;
  localparam int STG_EXEC   = 2;
  localparam int STG_ACCESS = 3;
  localparam int STG_WB     = 4;

  // Wait-timer width; at least one bit so a disabled timeout still elaborates.
  function automatic int timer_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// rtl/hazard_controller_if.sv - hazard request / stage control bundle between pipeline and controller
interface hazard_controller_if;
  logic        fwd_stall_rs1;
  logic        fwd_stall_rs2;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        halt_req;
  logic        fetch_en;
  logic        decode_en;
  logic        execute_en;
  logic        access_en;
  logic        writeback_en;
  logic        decode_bubble;
  logic        execute_bubble;
  logic        writeback_bubble;
  logic        pc_load;
  logic        halted;
  logic        mem_error;
  logic [31:0] perf_cycles;
  logic [31:0] perf_stalls;
  logic [31:0] perf_flushes;

  // Pipeline side: raises requests, consumes stage controls
  modport master (
    output fwd_stall_rs1, fwd_stall_rs2, branch_taken, mem_req, mem_ready, halt_req,
    input  fetch_en, decode_en, execute_en, access_en, writeback_en,
    input  decode_bubble, execute_bubble, writeback_bubble, pc_load,
    input  halted, mem_error, perf_cycles, perf_stalls, perf_flushes
  );

  // Controller side
  modport slave (
    input  fwd_stall_rs1, fwd_stall_rs2, branch_taken, mem_req, mem_ready, halt_req,
    output fetch_en, decode_en, execute_en, access_en, writeback_en,
    output decode_bubble, execute_bubble, writeback_bubble, pc_load,
    output halted, mem_error, perf_cycles, perf_stalls, perf_flushes
  );
endinterface

// File: rtl/hazard_controller_perf_counters.sv
// rtl/hazard_controller_perf_counters.sv - perf_counters: three wrapping 32-bit event counters (used with HAZARD_PERF_COUNTERS_EN)
module perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_cycles,
  input  logic        inc_stalls,
  input  logic        inc_flushes,
  output logic [31:0] cycles,
  output logic [31:0] stalls,
  output logic [31:0] flushes
);

  logic [31:0] cycles_q, cycles_d;
  logic [31:0] stalls_q, stalls_d;
  logic [31:0] flushes_q, flushes_d;

  // Increment each counter on its event; natural 32-bit wrap
  always_comb begin
    cycles_d  = cycles_q  + {31'd0, inc_cycles};
    stalls_d  = stalls_q  + {31'd0, inc_stalls};
    flushes_d = flushes_q + {31'd0, inc_flushes};
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles_q  <= '0;
      stalls_q  <= '0;
      flushes_q <= '0;
    end else begin
      cycles_q  <= cycles_d;
      stalls_q  <= stalls_d;
      flushes_q <= flushes_d;
    end
  end

  assign cycles  = cycles_q;
  assign stalls  = stalls_q;
  assign flushes = flushes_q;

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - five-stage pipeline sequencer (optional HAZARD_PERF_COUNTERS_EN adds perf counters)
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  hazard_controller_if.slave             hz,
  output stage_ctrl_t [NUM_STAGES-1:0]   stage_ctrl
);

  localparam int TW = timer_width(MEM_TIMEOUT);
  localparam logic [TW-1:0] TIMER_MAX = '1;

  hazard_state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          mem_error_q, mem_error_d;

  logic fe, de, ee, ae, we;
  logic db, eb, wb;
  logic pl, halted_o;
  logic timer_hit;

  // Next wait cycle would reach the timeout threshold
  assign timer_hit = (MEM_TIMEOUT != 0) && ((int'(timer_q) + 1) >= MEM_TIMEOUT);

  // Next-state and stage-control decode; reset forces the IDLE flush pattern
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    mem_error_d = mem_error_q;
    fe = 1'b0; de = 1'b0; ee = 1'b0; ae = 1'b0; we = 1'b0;
    db = 1'b0; eb = 1'b0; wb = 1'b0;
    pl = 1'b0;
    halted_o = 1'b0;

    if (rst) begin
      de = 1'b1; ee = 1'b1; ae = 1'b1; we = 1'b1;
      db = 1'b1; eb = 1'b1; wb = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          de = 1'b1; ee = 1'b1; ae = 1'b1; we = 1'b1;
          db = 1'b1; eb = 1'b1; wb = 1'b1;
          state_d = RUN;
        end
        RUN, MEM_WAIT: begin
          if (state_q == MEM_WAIT && !hz.mem_ready) begin
            // Still waiting: drain writeback only, count the wait
            we = 1'b1; wb = 1'b1;
            timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);
            if (timer_hit) begin
              mem_error_d = 1'b1;
              state_d     = HALTED;
            end
          end else if (hz.halt_req) begin
            state_d = HALTED;
          end else if (state_q == RUN && hz.mem_req && !hz.mem_ready) begin
            we = 1'b1; wb = 1'b1;
            timer_d = '0;
            state_d = MEM_WAIT;
          end else begin
            state_d = RUN;
            if (hz.branch_taken) begin
              // Branch beats a forwarding stall: the stalled decode op is wrong-path
              fe = 1'b1; de = 1'b1; ee = 1'b1; ae = 1'b1; we = 1'b1;
              pl = 1'b1; db = 1'b1; eb = 1'b1;
            end else if (hz.fwd_stall_rs1 || hz.fwd_stall_rs2) begin
              ee = 1'b1; eb = 1'b1; ae = 1'b1; we = 1'b1;
            end else begin
              fe = 1'b1; de = 1'b1; ee = 1'b1; ae = 1'b1; we = 1'b1;
            end
          end
        end
        HALTED: begin
          halted_o = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, wait timer and sticky error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign hz.fetch_en         = fe;
  assign hz.decode_en        = de;
  assign hz.execute_en       = ee;
  assign hz.access_en        = ae;
  assign hz.writeback_en     = we;
  assign hz.decode_bubble    = db;
  assign hz.execute_bubble   = eb;
  assign hz.writeback_bubble = wb;
  assign hz.pc_load          = pl;
  assign hz.halted           = halted_o;
  assign hz.mem_error        = mem_error_q & ~rst;

  assign stage_ctrl[STG_FETCH]  = {fe, 1'b0};
  assign stage_ctrl[STG_DECODE] = {de, db};
  assign stage_ctrl[STG_EXEC]   = {ee, eb};
  assign stage_ctrl[STG_ACCESS] = {ae, 1'b0};
  assign stage_ctrl[STG_WB]     = {we, wb};

`ifdef HAZARD_PERF_COUNTERS_EN
  perf_counters u_perf (
    .clk         (clk),
    .rst         (rst),
    .inc_cycles  (state_q != HALTED),
    .inc_stalls  (!fe && (state_q == RUN || state_q == MEM_WAIT)),
    .inc_flushes (pl),
    .cycles      (hz.perf_cycles),
    .stalls      (hz.perf_stalls),
    .flushes     (hz.perf_flushes)
  );
`else
  assign hz.perf_cycles  = '0;
  assign hz.perf_stalls  = '0;
  assign hz.perf_flushes = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - scoreboard bench for hazard_controller with directed vectors
module tb_hazard_controller;
  import hazard_controller_pkg::*;

  // input bits {rs1, rs2, br, req, rdy, halt}
  localparam logic [5:0] I_NONE = 6'b000000;
  localparam logic [5:0] I_RS1  = 6'b100000;
  localparam logic [5:0] I_RS2  = 6'b010000;
  localparam logic [5:0] I_BR   = 6'b001000;
  localparam logic [5:0] I_REQ  = 6'b000100;
  localparam logic [5:0] I_RDY  = 6'b000010;
  localparam logic [5:0] I_HALT = 6'b000001;

  // expected {fe,de,ee,ae,we, db,eb,wb, pl, halted, mem_error}
  localparam logic [10:0] E_IDLE = 11'b01111_111_0_00;
  localparam logic [10:0] E_RUN  = 11'b11111_000_0_00;
  localparam logic [10:0] E_MEMW = 11'b00001_001_0_00;
  localparam logic [10:0] E_BR   = 11'b11111_110_1_00;
  localparam logic [10:0] E_STL  = 11'b00111_010_0_00;
  localparam logic [10:0] E_FRZ  = 11'b00000_000_0_00;
  localparam logic [10:0] E_HLT  = 11'b00000_000_0_10;
  localparam logic [10:0] E_HLTE = 11'b00000_000_0_11;

  // st: 0 IDLE, 1 RUN/MEM_WAIT, 2 HALTED
  typedef struct {
    int          idx;
    logic [10:0] exp;
    logic [31:0] pc, ps, pf;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  stage_ctrl_t [NUM_STAGES-1:0] stage_ctrl;
  hazard_controller_if hz();

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  vec_n = 0;
  logic [31:0] m_cyc = 0, m_stl = 0, m_fls = 0;

  hazard_controller #(.MEM_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .hz         (hz),
    .stage_ctrl (stage_ctrl)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [5:0] in, input logic [10:0] exp, input int st);
    sb_t it;
    @(posedge clk);
    #1;
    rst              = r;
    hz.fwd_stall_rs1 = in[5];
    hz.fwd_stall_rs2 = in[4];
    hz.branch_taken  = in[3];
    hz.mem_req       = in[2];
    hz.mem_ready     = in[1];
    hz.halt_req      = in[0];
    it.idx = vec_n;
    it.exp = exp;
    it.pc  = m_cyc;
    it.ps  = m_stl;
    it.pf  = m_fls;
    sb.push_back(it);
    vec_n++;
`ifdef HAZARD_PERF_COUNTERS_EN
    if (r) begin
      m_cyc = 0; m_stl = 0; m_fls = 0;
    end else begin
      if (st != 2) m_cyc = m_cyc + 1;
      if (st == 1 && !exp[10]) m_stl = m_stl + 1;
      if (exp[2]) m_fls = m_fls + 1;
    end
`else
    if (st > 2) $display("note: unexpected state class %0d", st);
`endif
  endtask

  // Monitor: compare DUT outputs against the oldest expectation each cycle
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      sb_t it;
      logic [10:0] act;
      logic [9:0]  sc_exp;
      it  = sb.pop_front();
      act = {hz.fetch_en, hz.decode_en, hz.execute_en, hz.access_en, hz.writeback_en,
             hz.decode_bubble, hz.execute_bubble, hz.writeback_bubble,
             hz.pc_load, hz.halted, hz.mem_error};
      n_cmp++;
      if (act !== it.exp) begin
        n_bad++;
        $display("FAIL ctrl vec%0d got %b want %b", it.idx, act, it.exp);
      end
      sc_exp = {it.exp[6], it.exp[3], it.exp[7], 1'b0, it.exp[8], it.exp[4],
                it.exp[9], it.exp[5], it.exp[10], 1'b0};
      n_cmp++;
      if (stage_ctrl !== sc_exp) begin
        n_bad++;
        $display("FAIL stage_ctrl vec%0d got %b want %b", it.idx, stage_ctrl, sc_exp);
      end
      n_cmp++;
      if (hz.perf_cycles !== it.pc || hz.perf_stalls !== it.ps || hz.perf_flushes !== it.pf) begin
        n_bad++;
        $display("FAIL perf vec%0d got %0d/%0d/%0d want %0d/%0d/%0d", it.idx,
                 hz.perf_cycles, hz.perf_stalls, hz.perf_flushes, it.pc, it.ps, it.pf);
      end
    end
  end

  initial begin
    hz.fwd_stall_rs1 = 1'b0;
    hz.fwd_stall_rs2 = 1'b0;
    hz.branch_taken  = 1'b0;
    hz.mem_req       = 1'b0;
    hz.mem_ready     = 1'b0;
    hz.halt_req      = 1'b0;

    // reset and pipeline fill
    step(1, I_NONE, E_IDLE, 0);
    step(1, I_NONE, E_IDLE, 0);
    step(0, I_NONE, E_IDLE, 0);
    step(0, I_NONE, E_RUN, 1);
    // two-cycle load-use stall
    step(0, I_RS1, E_STL, 1);
    step(0, I_RS1, E_STL, 1);
    step(0, I_NONE, E_RUN, 1);
    // three-cycle memory wait, release on the fourth
    step(0, I_REQ, E_MEMW, 1);
    step(0, I_REQ, E_MEMW, 1);
    step(0, I_REQ, E_MEMW, 1);
    step(0, I_REQ | I_RDY, E_RUN, 1);
    // branch beats forwarding stall
    step(0, I_BR | I_RS2, E_BR, 1);
    // branch held behind a memory wait is applied on release
    step(0, I_REQ | I_BR, E_MEMW, 1);
    step(0, I_REQ | I_RDY | I_BR, E_BR, 1);
    step(0, I_NONE, E_RUN, 1);
    // halt from RUN
    step(0, I_HALT, E_FRZ, 1);
    step(0, I_NONE, E_HLT, 2);
    step(0, I_RS1 | I_BR, E_HLT, 2);
    step(1, I_NONE, E_IDLE, 0);
    step(0, I_NONE, E_IDLE, 0);
    step(0, I_NONE, E_RUN, 1);
    // halt during MEM_WAIT with mem_ready
    step(0, I_REQ, E_MEMW, 1);
    step(0, I_REQ | I_RDY | I_HALT, E_FRZ, 1);
    step(0, I_NONE, E_HLT, 2);
    step(1, I_NONE, E_IDLE, 0);
    step(0, I_NONE, E_IDLE, 0);
    step(0, I_NONE, E_RUN, 1);
    // timeout after four wait cycles
    step(0, I_REQ, E_MEMW, 1);
    step(0, I_REQ, E_MEMW, 1);
    step(0, I_REQ, E_MEMW, 1);
    step(0, I_REQ, E_MEMW, 1);
    step(0, I_REQ, E_MEMW, 1);
    step(0, I_REQ, E_HLTE, 2);
    step(0, I_REQ | I_RDY, E_HLTE, 2);
    step(1, I_NONE, E_IDLE, 0);
    step(0, I_NONE, E_IDLE, 0);
    step(0, I_NONE, E_RUN, 1);
    // reset in the middle of a memory wait
    step(0, I_REQ, E_MEMW, 1);
    step(0, I_REQ, E_MEMW, 1);
    step(1, I_REQ, E_IDLE, 0);
    step(0, I_NONE, E_IDLE, 0);
    step(0, I_NONE, E_RUN, 1);
    // same-cycle ready: no MEM_WAIT entry
    step(0, I_REQ | I_RDY, E_RUN, 1);
    step(0, I_NONE, E_RUN, 1);
    step(0, I_RS2, E_STL, 1);
    step(0, I_NONE, E_RUN, 1);

    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Central pipeline sequencer for the five-stage core. Collects stall requests from the two operand forwarders, the taken-branch signal from execute, the memory handshake from the access stage and the halt request from writeback. Produces per-stage register enables, bubble inserts and the PC-load strobe. Runs a small FSM covering pipeline fill after reset, multi-cycle memory waits with a timeout, and halt.

## Interface
Parameters:
- MEM_TIMEOUT, default 64: maximum cycles spent in MEM_WAIT before an error; 0 disables the timeout.

Ports:
- clk  in  1  core clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- fwd_stall_rs1  in  1  stall request from the rs1 forwarder
- fwd_stall_rs2  in  1  stall request from the rs2 forwarder
- branch_taken  in  1  execute resolves a taken branch or jump this cycle
- mem_req  in  1  access stage holds a load or store
- mem_ready  in  1  memory completes the access this cycle
- halt_req  in  1  writeback holds ebreak/ecall-halt
- fetch_en, decode_en, execute_en, access_en, writeback_en  out  1 each  stage input register captures this cycle
- decode_bubble, execute_bubble, writeback_bubble  out  1 each  captured value is a NOP (valid cleared)
- pc_load  out  1  fetch loads the branch target instead of PC+4
- halted  out  1  core stopped
- mem_error  out  1  sticky memory-timeout flag
- perf_cycles, perf_stalls, perf_flushes  out  32 each  performance counters (see Configuration)

## Operation
- States: IDLE, RUN, MEM_WAIT, HALTED. Outputs are combinational from state and inputs. Any output not listed for a case is 0.
- IDLE:
  - fetch_en=0; decode/execute/access/writeback_en=1; all bubbles=1.
  - Flushes the pipeline. Next state RUN unconditionally.
- RUN, rules in priority order:
  1. halt_req: all enables 0; next HALTED.
  2. mem_req && !mem_ready: all enables 0 except writeback_en=1 with writeback_bubble=1; next MEM_WAIT; wait timer cleared to 0.
  3. branch_taken: all enables 1; pc_load=1; decode_bubble=1; execute_bubble=1.
  4. fwd_stall_rs1 || fwd_stall_rs2: fetch_en=0, decode_en=0; execute_en=1 with execute_bubble=1; access_en=1, writeback_en=1.
  5. Otherwise: all enables 1, no bubbles.
- MEM_WAIT:
  - mem_ready=1: evaluate RUN rules 1, 3, 4, 5 this cycle. Next state RUN, or HALTED if rule 1 fires.
  - mem_ready=0: outputs as RUN rule 2; timer increments.
  - Timer reaches MEM_TIMEOUT (with MEM_TIMEOUT≠0) and mem_ready=0: mem_error set, next HALTED.
- HALTED:
  - All enables 0; halted=1. Only rst leaves this state.
- A branch held in a frozen execute stage is not lost. branch_taken stays asserted and is applied on the first non-memory-stalled cycle.

## Timing
- Reset: state IDLE, timer 0, mem_error 0, counters 0. Outputs during reset follow IDLE.
- Reset asserted in any state, including mid MEM_WAIT, takes effect on the next edge.
- Zero-latency control: the decision in cycle N gates the captures at the edge ending cycle N.
- Load-use stall: each cycle of fwd_stall yields exactly one bubble. Fetch/decode resume in the cycle the request drops.
- Timer width: clog2(MEM_TIMEOUT+1). Saturates and never wraps.
- Simultaneous branch_taken and fwd_stall: the branch wins. The stalled decode instruction is wrong-path and is bubbled.
- mem_ready=1 in the same RUN cycle as mem_req: no MEM_WAIT entry.

## Configuration
- HAZARD_PERF_COUNTERS_EN defined:
  - perf_cycles increments every non-reset cycle outside HALTED.
  - perf_stalls increments on every cycle with fetch_en=0 in RUN or MEM_WAIT.
  - perf_flushes increments on every pc_load.
  - All three wrap at 2^32 and clear on rst.
- Not defined: all three outputs are tied to 0 and no counter flops are built.

## Structure
- cpu_types package gains:
  - hazard_state_t enum (IDLE, RUN, MEM_WAIT, HALTED)
  - stage_ctrl_t struct (en, bubble) per stage, for a packed output bundle alongside the ports
- Sub-module perf_counters (three 32-bit counters, increment inputs), instantiated only under HAZARD_PERF_COUNTERS_EN.

## Test plan
- Reset release: cycle 0 after rst: fetch_en=0, all bubbles=1. Cycle 1: RUN, all enables 1.
- fwd_stall_rs1 high for 2 cycles → fetch_en=decode_en=0 and execute_bubble=1 for exactly 2 cycles; perf_stalls +2.
- mem_req=1 with mem_ready low 3 cycles → MEM_WAIT, 3 writeback bubbles, release on the 4th cycle with all enables 1.
- MEM_TIMEOUT=4, mem_ready never asserted → mem_error=1 and halted=1 after 4 wait cycles; both hold until rst.
- branch_taken with fwd_stall_rs2 → pc_load=1, decode_bubble=execute_bubble=1, fetch_en=1; perf_flushes +1.
- halt_req during MEM_WAIT with mem_ready=1 → HALTED next cycle; rst then returns to IDLE with counters 0.
